mem_arb_1r1w: RTL and testbench

MEM_ARB_1R1W -- requirements
Module: mem_arb_1r1w

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_1r1w_if.sv | 28 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/mem_arb_1r1w.sv | 135 +++++++++++++
 tb/tb_mem_arb_1r1w.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester 1R1W memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/mem_arb_1r1w_if.sv
// Requester-side bus of mem_arb_1r1w: two request channels plus a shared response.
// Handshake: a request transfers on a cycle where req_valid_i[n] and req_ready_o[n] are both 1;
// valid/we/addr/wdata stay stable until then and valid never waits on ready. Responses carry no ready.
interface mem_arb_1r1w_if #(
  parameter int WIDTH = mem_arb_pkg::DEF_WIDTH,
  parameter int DEPTH = mem_arb_pkg::DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]            req_valid_i;
  logic [1:0]            req_we_i;
  logic [1:0][AW-1:0]    req_addr_i;
  logic [1:0][WIDTH-1:0] req_wdata_i;
  logic [1:0]            req_ready_o;
  logic [1:0]            rsp_valid_o;
  logic [WIDTH-1:0]      rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: combinational grant, pointer flips to the other requester after a grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (r_ptr == REQ_ID1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= REQ_ID0;
    end else if (o_gnt[0]) begin
      r_ptr <= REQ_ID1;
    end else if (o_gnt[1]) begin
      r_ptr <= REQ_ID0;
    end
  end

endmodule

// File: rtl/mem_arb_1r1w.sv
// Clears an external 1R1W memory after reset, then arbitrates two requesters onto its ports.
// Define MEM_ARB_FWD_EN to forward same-cycle write data to a colliding read.
module mem_arb_1r1w
  import mem_arb_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  mem_arb_1r1w_if.slave    bus,
  output logic [AW-1:0]    rd_addr0,
  output logic [AW-1:0]    wr_addr0,
  output logic [WIDTH-1:0] wr_din0,
  output logic             we0,
  input  logic [WIDTH-1:0] rd_dout0,
  output state_t           o_state
);

  state_t        r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_rd_addr;
  logic          r_rsp_vld;
  logic          r_rsp_tag;

  logic          w_run;
  logic [1:0]    w_rd_req;
  logic [1:0]    w_wr_req;
  logic [1:0]    w_rd_gnt;
  logic [1:0]    w_wr_gnt;
  logic          w_rd_sel;
  logic          w_wr_sel;

  assign w_run    = (r_state == ST_RUN);
  assign w_rd_req = bus.req_valid_i & ~bus.req_we_i & {2{w_run}};
  assign w_wr_req = bus.req_valid_i &  bus.req_we_i & {2{w_run}};

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst),
    .i_req (w_rd_req),
    .o_gnt (w_rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst),
    .i_req (w_wr_req),
    .o_gnt (w_wr_gnt)
  );

  assign w_rd_sel        = w_rd_gnt[1];
  assign w_wr_sel        = w_wr_gnt[1];
  assign bus.req_ready_o = w_rd_gnt | w_wr_gnt;
  assign o_state         = r_state;

  // Read address holds its last granted value so the memory output stays stable when idle.
  always_comb begin
    rd_addr0 = r_rd_addr;
    if (|w_rd_gnt) begin
      rd_addr0 = bus.req_addr_i[w_rd_sel];
    end
  end

  // we0 is gated by rst so the memory sees no write while reset is held.
  always_comb begin
    we0      = 1'b0;
    wr_addr0 = '0;
    wr_din0  = '0;
    if (rst) begin
      if (!w_run) begin
        we0      = 1'b1;
        wr_addr0 = r_clr_cnt;
      end else if (|w_wr_gnt) begin
        we0      = 1'b1;
        wr_addr0 = bus.req_addr_i[w_wr_sel];
        wr_din0  = bus.req_wdata_i[w_wr_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_rd_addr <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_tag <= REQ_ID0;
    end else begin
      r_rsp_vld <= |w_rd_gnt;
      if (|w_rd_gnt) begin
        r_rsp_tag <= w_rd_sel;
        r_rd_addr <= bus.req_addr_i[w_rd_sel];
      end
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == AW'(DEPTH - 1)) begin
            r_state   <= ST_RUN;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign bus.rsp_valid_o = {r_rsp_vld & r_rsp_tag, r_rsp_vld & ~r_rsp_tag};

`ifdef MEM_ARB_FWD_EN
  logic             r_fwd_hit;
  logic [WIDTH-1:0] r_fwd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit <= (|w_rd_gnt) && (|w_wr_gnt) &&
                   (bus.req_addr_i[w_rd_sel] == bus.req_addr_i[w_wr_sel]);
      if (|w_wr_gnt) begin
        r_fwd_data <= bus.req_wdata_i[w_wr_sel];
      end
    end
  end

  assign bus.rsp_rdata_o = r_fwd_hit ? r_fwd_data : rd_dout0;
`else
  assign bus.rsp_rdata_o = rd_dout0;
`endif

endmodule

// File: tb/tb_mem_arb_1r1w.sv
// Bench for mem_arb_1r1w: directed scenarios plus random traffic against a behavioural model.
module tb_mem_arb_1r1w;
  import mem_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef MEM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [AW-1:0]    rd_addr0;
  logic [AW-1:0]    wr_addr0;
  logic [WIDTH-1:0] wr_din0;
  logic             we0;
  logic [WIDTH-1:0] rd_dout0;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  bit               exp_tag_q [$];
  int               last_rd;
  int               last_wr;

  mem_arb_1r1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_arb_1r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rd_addr0 (rd_addr0),
    .wr_addr0 (wr_addr0),
    .wr_din0  (wr_din0),
    .we0      (we0),
    .rd_dout0 (rd_dout0),
    .o_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // external 1R1W memory, read data one cycle after address, pre-write value on collision
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (we0) mem[wr_addr0] <= wr_din0;
    rd_dout0 <= mem[rd_addr0];
  end

  // driver tasks
  task automatic drive_idle();
    bus.req_valid_i = 2'b00;
    bus.req_we_i    = 2'b00;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (DEPTH) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_q.delete();
    exp_tag_q.delete();
    last_rd = 1;
    last_wr = 1;
  endtask

  // tie goes to the requester that did not win last time
  function automatic int pick(bit a, bit b, int last);
    if (a && b) return (last == 0) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", bus.req_ready_o); end
    n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 00", bus.rsp_valid_o); end
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL rst_we0: got %b expected 0", we0); end
    n_checks++; if (rd_addr0 !== '0 || wr_addr0 !== '0 || wr_din0 !== '0) begin n_fail++; $display("FAIL rst_addr: got rd %0h wr %0h din %0h expected 0", rd_addr0, wr_addr0, wr_din0); end
    @(negedge clk);
    bus.req_valid_i = 2'b11;
    bus.req_we_i    = 2'b00;
    bus.req_addr_i[0] = AW'(1);
    bus.req_addr_i[1] = AW'(1);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++; if (we0 !== 1'b1 || wr_addr0 !== AW'(i) || wr_din0 !== '0) begin n_fail++; $display("FAIL clear_write[%0d]: got we %b addr %0d din %0h expected we 1 addr %0d din 0", i, we0, wr_addr0, wr_din0, i); end
      n_checks++; if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL clear_quiet[%0d]: got ready %b rsp %b expected 00 00", i, bus.req_ready_o, bus.rsp_valid_o); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL run_state: got %0d expected %0d", dbg_state, ST_RUN); end
    n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL run_first_ready: got %b expected 01", bus.req_ready_o); end
    n_checks++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL run_we0: got %b expected 0", we0); end
    drive_idle();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.req_valid_i    = 2'b01;
    bus.req_we_i       = 2'b01;
    bus.req_addr_i[0]  = AW'(4);
    bus.req_wdata_i[0] = 32'h1F;
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b expected 01", bus.req_ready_o); end
    n_checks++; if (we0 !== 1'b1 || wr_addr0 !== AW'(4) || wr_din0 !== 32'h1F) begin n_fail++; $display("FAIL wr_port: got we %b addr %0d din %0h expected 1 4 1f", we0, wr_addr0, wr_din0); end
    @(negedge clk);
    drive_idle();
    bus.req_valid_i   = 2'b10;
    bus.req_addr_i[1] = AW'(4);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b10 || rd_addr0 !== AW'(4) || we0 !== 1'b0) begin n_fail++; $display("FAIL rd_accept: got ready %b rd_addr %0d we %b expected 10 4 0", bus.req_ready_o, rd_addr0, we0); end
    @(negedge clk);
    drive_idle();
    n_checks++; if (bus.rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 10", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_rdata_o !== 32'h1F) begin n_fail++; $display("FAIL rd_rsp_data: got %0h expected 1f", bus.rsp_rdata_o); end
  endtask

  task automatic test_alternate();
    logic [1:0]       exp_g [4];
    logic [WIDTH-1:0] exp_d;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk);
    bus.req_valid_i   = 2'b11;
    bus.req_we_i      = 2'b00;
    bus.req_addr_i[0] = AW'(4);
    bus.req_addr_i[1] = AW'(7);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus.req_ready_o !== exp_g[k]) begin n_fail++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, bus.req_ready_o, exp_g[k]); end
      @(negedge clk);
      exp_d = (exp_g[k] == 2'b01) ? 32'h1F : 32'h0;
      n_checks++; if (bus.rsp_valid_o !== exp_g[k] || bus.rsp_rdata_o !== exp_d) begin n_fail++; $display("FAIL alt_rsp[%0d]: got %b/%0h expected %b/%0h", k, bus.rsp_valid_o, bus.rsp_rdata_o, exp_g[k], exp_d); end
    end
    drive_idle();
  endtask

  task automatic test_same_addr();
    logic [WIDTH-1:0] exp_d;
    exp_d = FWD ? 32'hAA : 32'h0;
    @(negedge clk);
    bus.req_valid_i    = 2'b11;
    bus.req_we_i       = 2'b01;
    bus.req_addr_i[0]  = AW'(2);
    bus.req_wdata_i[0] = 32'hAA;
    bus.req_addr_i[1]  = AW'(2);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b11) begin n_fail++; $display("FAIL same_ready: got %b expected 11", bus.req_ready_o); end
    n_checks++; if (we0 !== 1'b1 || wr_addr0 !== AW'(2) || rd_addr0 !== AW'(2)) begin n_fail++; $display("FAIL same_ports: got we %b wr %0d rd %0d expected 1 2 2", we0, wr_addr0, rd_addr0); end
    @(negedge clk);
    drive_idle();
    n_checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_rdata_o !== exp_d) begin n_fail++; $display("FAIL same_rsp: got %b/%0h expected 10/%0h", bus.rsp_valid_o, bus.rsp_rdata_o, exp_d); end
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = AW'(2);
    @(negedge clk);
    drive_idle();
    n_checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_rdata_o !== 32'hAA) begin n_fail++; $display("FAIL same_reread: got %b/%0h expected 01/aa", bus.rsp_valid_o, bus.rsp_rdata_o); end
  endtask

  task automatic test_random();
    bit               p_act [2];
    bit               p_we [2];
    logic [AW-1:0]    p_addr [2];
    logic [WIDTH-1:0] p_data [2];
    logic [1:0]       exp_v;
    logic [1:0]       exp_rdy;
    logic [WIDTH-1:0] exp_d;
    int               rw;
    int               ww;
    apply_reset();
    p_act = '{0, 0};
    for (int cyc = 0; cyc <= 600; cyc++) begin
      exp_v = 2'b00;
      exp_d = '0;
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        exp_v = exp_tag_q.pop_front() ? 2'b10 : 2'b01;
      end
      n_checks++; if (bus.rsp_valid_o !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", cyc, bus.rsp_valid_o, exp_v); end
      if (exp_v != 2'b00) begin
        n_checks++; if (bus.rsp_rdata_o !== exp_d) begin n_fail++; $display("FAIL rnd_rsp_data@%0d: got %0h expected %0h", cyc, bus.rsp_rdata_o, exp_d); end
      end
      if (cyc == 600) break;
      for (int n = 0; n < 2; n++) begin
        if (!p_act[n] && $urandom_range(0, 9) < 7) begin
          p_act[n]  = 1'b1;
          p_we[n]   = 1'($urandom_range(0, 1));
          p_addr[n] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
          p_data[n] = WIDTH'($urandom);
        end
        bus.req_valid_i[n] = p_act[n];
        bus.req_we_i[n]    = p_we[n];
        bus.req_addr_i[n]  = p_addr[n];
        bus.req_wdata_i[n] = p_data[n];
      end
      #1;
      rw = pick(p_act[0] && !p_we[0], p_act[1] && !p_we[1], last_rd);
      ww = pick(p_act[0] &&  p_we[0], p_act[1] &&  p_we[1], last_wr);
      exp_rdy = 2'b00;
      if (rw >= 0) exp_rdy[rw] = 1'b1;
      if (ww >= 0) exp_rdy[ww] = 1'b1;
      n_checks++; if (bus.req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, bus.req_ready_o, exp_rdy); end
      n_checks++; if (we0 !== (ww >= 0)) begin n_fail++; $display("FAIL rnd_we0@%0d: got %b expected %b", cyc, we0, ww >= 0); end
      if (ww >= 0) begin
        n_checks++; if (wr_addr0 !== p_addr[ww] || wr_din0 !== p_data[ww]) begin n_fail++; $display("FAIL rnd_wr_port@%0d: got %0d/%0h expected %0d/%0h", cyc, wr_addr0, wr_din0, p_addr[ww], p_data[ww]); end
      end
      if (rw >= 0) begin
        n_checks++; if (rd_addr0 !== p_addr[rw]) begin n_fail++; $display("FAIL rnd_rd_addr@%0d: got %0d expected %0d", cyc, rd_addr0, p_addr[rw]); end
        exp_d = ref_mem[p_addr[rw]];
        if (FWD && ww >= 0 && p_addr[ww] == p_addr[rw]) exp_d = p_data[ww];
        exp_q.push_back(exp_d);
        exp_tag_q.push_back(rw == 1);
        last_rd   = rw;
        p_act[rw] = 1'b0;
      end
      if (ww >= 0) begin
        ref_mem[p_addr[ww]] = p_data[ww];
        last_wr   = ww;
        p_act[ww] = 1'b0;
      end
      @(negedge clk);
      drive_idle();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid_i   = 2'b01;
    bus.req_we_i      = 2'b00;
    bus.req_addr_i[0] = AW'(3);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL mid_accept: got %b expected 01", bus.req_ready_o); end
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b00 || we0 !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL mid_in_reset: got ready %b we %b rsp %b expected 00 0 00", bus.req_ready_o, we0, bus.rsp_valid_o); end
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL mid_no_rsp[%0d]: got %b expected 00", i, bus.rsp_valid_o); end
      n_checks++; if (dbg_state !== ST_CLEAR || we0 !== 1'b1 || wr_addr0 !== AW'(i)) begin n_fail++; $display("FAIL mid_restart[%0d]: got state %0d we %b addr %0d expected 0 1 %0d", i, dbg_state, we0, wr_addr0, i); end
      @(negedge clk);
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_same_addr();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
